// File: rtl/fir_loader_pkg.sv
// Shared types and sizing helpers for the FIR coefficient loader.
package fir_loader_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Never returns 0 so that single-value fields still get a 1-bit port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int idx_width(input int ntaps);
        return clog2_min1(ntaps);
    endfunction

    function automatic int bank_width(input int nbanks);
        return clog2_min1(nbanks);
    endfunction

    function automatic int addr_width(input int nbanks, input int ntaps);
        return clog2_min1(nbanks * ntaps);
    endfunction

    function automatic int unsigned tap_addr(input int unsigned bank,
                                             input int unsigned ntaps,
                                             input int unsigned k);
        return bank * ntaps + k;
    endfunction

endpackage

// File: rtl/fir_tap_delay_line.sv
// Delays {valid, idx} by DEPTH cycles to line up with ROM read data.
module tap_delay_line #(
    parameter int DEPTH = 1,
    parameter int IW    = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_flush,
    input  logic          i_valid,
    input  logic [IW-1:0] i_idx,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic          r_valid;
            logic [IW-1:0] r_idx;
            if (gi == 0) begin : g_head
                always_ff @(posedge i_clk) begin
                    if (i_reset || i_flush) r_valid <= 1'b0;
                    else                    r_valid <= i_valid;
                    if (i_reset) r_idx <= '0;
                    else         r_idx <= i_idx;
                end
            end else begin : g_tail
                always_ff @(posedge i_clk) begin
                    if (i_reset || i_flush) r_valid <= 1'b0;
                    else                    r_valid <= g_stage[gi-1].r_valid;
                    if (i_reset) r_idx <= '0;
                    else         r_idx <= g_stage[gi-1].r_idx;
                end
            end
        end
    endgenerate

    assign o_valid = g_stage[DEPTH-1].r_valid;
    assign o_idx   = g_stage[DEPTH-1].r_idx;

endmodule

// File: rtl/fir_tap_loader.sv
// Streams one bank of coefficients from a synchronous ROM into a FIR tap-write
// port, holding the filter enable low until a full tap set is resident.
module fir_tap_loader
    import fir_loader_pkg::*;
#(
    parameter int NTAPS   = 16,
    parameter int TAP_W   = 16,
    parameter int NBANKS  = 4,
    parameter int ROM_LAT = 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_start,
    input  logic [bank_width(NBANKS)-1:0]        i_bank,
    input  logic                                 i_abort,
    input  logic                                 i_ce,
    output logic                                 o_rom_en,
    output logic [addr_width(NBANKS,NTAPS)-1:0]  o_rom_addr,
    input  logic [TAP_W-1:0]                     i_rom_data,
    output logic                                 o_tap_wr,
    output logic [TAP_W-1:0]                     o_tap,
    output logic [idx_width(NTAPS)-1:0]          o_tap_idx,
    output logic                                 o_ce,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_err,
    output logic                                 o_loaded,
    output logic [bank_width(NBANKS)-1:0]        o_bank_active
);

    localparam int IW = idx_width(NTAPS);
    localparam int BW = bank_width(NBANKS);
    localparam int AW = addr_width(NBANKS, NTAPS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);
    localparam logic [BW:0]   NBANKS_W = (BW + 1)'(NBANKS);

    state_t          r_state, w_state_next;
    logic [IW-1:0]   r_k;
    logic [BW-1:0]   r_bank;
    logic            r_start_q, r_loaded, r_err;
    logic            r_tap_wr;
    logic [TAP_W-1:0] r_tap;
    logic [IW-1:0]   r_tap_idx;

    logic            w_start_edge, w_bank_ok, w_busy, w_abort, w_last_wr;
    logic            w_accept, w_reject, w_rom_en;
    logic            w_dl_valid;
    logic [IW-1:0]   w_dl_idx;

    assign w_start_edge = i_start & ~r_start_q;
    assign w_bank_ok    = {1'b0, i_bank} < NBANKS_W;
    assign w_busy       = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign w_abort      = w_busy & i_abort;
    assign w_last_wr    = r_tap_wr && (r_tap_idx == LAST_IDX);
    assign w_accept     = (r_state == S_IDLE) && w_start_edge && w_bank_ok;
    assign w_reject     = (r_state == S_IDLE) && w_start_edge && !w_bank_ok;
    assign w_rom_en     = (r_state == S_FETCH);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_FETCH;
            S_FETCH: begin
                if (i_abort)               w_state_next = S_IDLE;
                else if (r_k == LAST_IDX)  w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (i_abort)        w_state_next = S_IDLE;
                else if (w_last_wr) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Start register resets high so a request held through reset is not an edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_start_q <= 1'b1;
            r_k       <= '0;
            r_bank    <= '0;
            r_loaded  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_start_q <= i_start;
            r_err     <= w_reject;
            if (w_accept) begin
                r_k      <= '0;
                r_bank   <= i_bank;
                r_loaded <= 1'b0;
            end else begin
                if (w_rom_en) r_k <= r_k + IW'(1);
                if (r_state != S_DONE && w_state_next == S_DONE) r_loaded <= 1'b1;
            end
        end
    end

    tap_delay_line #(
        .DEPTH (ROM_LAT),
        .IW    (IW)
    ) u_delay (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (w_abort),
        .i_valid (w_rom_en),
        .i_idx   (r_k),
        .o_valid (w_dl_valid),
        .o_idx   (w_dl_idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tap_wr  <= 1'b0;
            r_tap     <= '0;
            r_tap_idx <= '0;
        end else begin
            r_tap_wr <= w_dl_valid & ~w_abort;
            if (w_dl_valid) begin
                r_tap     <= i_rom_data;
                r_tap_idx <= w_dl_idx;
            end
        end
    end

    assign o_rom_en      = w_rom_en;
    assign o_rom_addr    = w_rom_en ? AW'(tap_addr(32'(r_bank), NTAPS, 32'(r_k))) : '0;
    assign o_tap_wr      = r_tap_wr;
    assign o_tap         = r_tap;
    assign o_tap_idx     = r_tap_idx;
    assign o_busy        = w_busy;
    assign o_done        = (r_state == S_DONE);
    assign o_err         = r_err;
    assign o_loaded      = r_loaded;
    assign o_bank_active = r_bank;
    assign o_ce          = i_ce & r_loaded & ~w_busy;

endmodule
